// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic and arithmetic ops, compares and branch conditions complete in one cycle.
// Shifts step one bit per cycle through the SHIFT state.
// Optional build macro FAST_SHIFT_EN replaces the iterative shifter with a
// single-cycle barrel shifter, which makes every op single-cycle.
module alu_exec_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BranchTaken
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_XOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_BGE = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_BLT = 4'b1101;
  localparam logic [3:0] OP_SLT = 4'b1110;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  branch_r;
  logic                  valid_r;
  logic [SHAMT_W-1:0]    count_r;
  logic [3:0]            op_r;

  logic [SHAMT_W-1:0]    shamt_s;
  logic                  is_shift_s;
  logic                  load_iter_s;
  logic                  fire_s;
  logic                  in_ready_s;
  logic                  lt_s;
  logic [DATA_WIDTH-1:0] res_s;
  logic                  cond_s;

  // One-bit step of the iterative shifter; SRA replicates the sign bit.
  function automatic logic [DATA_WIDTH-1:0] shift_step(input logic [3:0] op,
                                                       input logic [DATA_WIDTH-1:0] v);
    case (op)
      OP_SLL:  shift_step = {v[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, v[DATA_WIDTH-1:1]};
      OP_SRA:  shift_step = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
      default: shift_step = v;
    endcase
  endfunction

  assign shamt_s    = SrcB[SHAMT_W-1:0];
  assign is_shift_s = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);
  assign lt_s       = $signed(SrcA) < $signed(SrcB);
  // A new op is accepted when idle, or when the held result leaves this same cycle.
  assign in_ready_s = !reset && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
  assign fire_s     = in_valid && in_ready_s;

`ifdef FAST_SHIFT_EN
  assign load_iter_s = 1'b0;
`else
  assign load_iter_s = is_shift_s && (shamt_s != {SHAMT_W{1'b0}});
`endif

  // Single-cycle result and branch condition for the op presented at the inputs.
  always_comb begin
    res_s  = {DATA_WIDTH{1'b0}};
    cond_s = 1'b0;
    case (Operation)
      OP_AND: res_s = SrcA & SrcB;
      OP_XOR: res_s = SrcA ^ SrcB;
      OP_OR:  res_s = SrcA | SrcB;
      OP_ADD: res_s = SrcA + SrcB;
      OP_SUB: res_s = SrcA - SrcB;
      OP_SLT: res_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      OP_LUI: res_s = SrcB;
`ifdef FAST_SHIFT_EN
      OP_SLL: res_s = SrcA << shamt_s;
      OP_SRL: res_s = SrcA >> shamt_s;
      OP_SRA: res_s = $signed(SrcA) >>> shamt_s;
`else
      // Only reached with a zero shift amount; non-zero amounts go to SHIFT.
      OP_SLL, OP_SRL, OP_SRA: res_s = SrcA;
`endif
      OP_BEQ: cond_s = (SrcA == SrcB);
      OP_BNE: cond_s = (SrcA != SrcB);
      OP_BLT: cond_s = lt_s;
      OP_BGE: cond_s = !lt_s;
      default: begin
        res_s  = {DATA_WIDTH{1'b0}};
        cond_s = 1'b0;
      end
    endcase
    if ((Operation == OP_BEQ) || (Operation == OP_BNE) ||
        (Operation == OP_BLT) || (Operation == OP_BGE)) begin
      res_s = {{(DATA_WIDTH-1){1'b0}}, cond_s};
    end else begin
      res_s = res_s;
    end
  end

  // Handshake FSM: accept, iterate shifts, hold the result until it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      result_r <= {DATA_WIDTH{1'b0}};
      branch_r <= 1'b0;
      valid_r  <= 1'b0;
      count_r  <= {SHAMT_W{1'b0}};
      op_r     <= 4'b0000;
    end else if (fire_s) begin
      if (load_iter_s) begin
        state_r  <= SHIFT;
        result_r <= SrcA;
        count_r  <= shamt_s;
        op_r     <= Operation;
        branch_r <= 1'b0;
        valid_r  <= 1'b0;
      end else begin
        state_r  <= DONE;
        result_r <= res_s;
        branch_r <= cond_s;
        valid_r  <= 1'b1;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        SHIFT: begin
          result_r <= shift_step(op_r, result_r);
          count_r  <= count_r - SHAMT_W'(1);
          if (count_r == SHAMT_W'(1)) begin
            state_r <= DONE;
            valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = valid_r;
  assign ALUResult   = result_r;
  assign BranchTaken = branch_r;

endmodule
